// File: rtl/fa_vector_driver.sv
// Exhaustive full-adder exerciser: sweeps all eight {A,B,Cin} vectors, lets each
// settle, checks the adder's Sout/Cout and counts failures with saturation.
module fa_vector_driver #(
    parameter int HOLD_CYCLES = 2,
    parameter int NUM_PASSES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       Cin,
    input  logic       Sout,
    input  logic       Cout,
    output logic       busy,
    output logic       done,
    output logic [2:0] vec_idx,
    output logic       mismatch,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] PASS_LAST = 4'(NUM_PASSES - 1);

    state_t     state;
    logic [3:0] hold_cnt;
    logic [3:0] pass_cnt;
    logic       start_req;
    logic       exp_sum;
    logic       exp_cout;
    logic       fail;

    always_comb begin
        {A, B, Cin} = 3'b000;
        if (state == APPLY || state == CHECK) begin
            {A, B, Cin} = vec_idx;
        end
        exp_sum  = ^vec_idx;
        exp_cout = (vec_idx[2] & vec_idx[1]) | (vec_idx[2] & vec_idx[0]) |
                   (vec_idx[1] & vec_idx[0]);
        fail     = (Sout != exp_sum) || (Cout != exp_cout);
    end

    // start is captured into start_req while idle/done; the run launches on the
    // following edge, which gives the one-cycle launch latency ahead of vector 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= 4'd0;
            pass_cnt  <= 4'd0;
            start_req <= 1'b0;
            vec_idx   <= 3'd0;
            err_cnt   <= 4'd0;
            mismatch  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    start_req <= start;
                    if (start_req) begin
                        state    <= APPLY;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        vec_idx  <= 3'd0;
                        pass_cnt <= 4'd0;
                        hold_cnt <= 4'd0;
                        err_cnt  <= 4'd0;
                    end
                end
                APPLY: begin
                    start_req <= 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= CHECK;
                        hold_cnt <= 4'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    start_req <= 1'b0;
                    if (fail) begin
                        mismatch <= 1'b1;
                        if (err_cnt != 4'd15) begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                    end
                    if (vec_idx != 3'd7) begin
                        vec_idx <= vec_idx + 3'd1;
                        state   <= APPLY;
                    end else if (pass_cnt != PASS_LAST) begin
                        vec_idx  <= 3'd0;
                        pass_cnt <= pass_cnt + 4'd1;
                        state    <= APPLY;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_vector_driver.sv
// Bench for fa_vector_driver: two instances (H=2,P=1 and H=1,P=3) driving a
// fault-injectable adder, checked against a run-timeline reference model.
module tb_fa_vector_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, start0, a0, b0, c0, sout0, cout0, busy0, done0, mis0;
    logic [2:0] vec0;
    logic [3:0] err0;
    logic rst1, start1, a1, b1, c1, sout1, cout1, busy1, done1, mis1;
    logic [2:0] vec1;
    logic [3:0] err1;

    logic       f_inv;
    logic       f_stuck;
    logic [7:0] f_mask;

    int checks = 0;
    int errors = 0;

    // Adder under test with optional Sout inversion, Cout stuck-at-0 and per-vector Sout flips.
    assign sout0 = a0 ^ b0 ^ c0 ^ f_inv ^ f_mask[{a0, b0, c0}];
    assign cout0 = f_stuck ? 1'b0 : ((a0 & b0) | (a0 & c0) | (b0 & c0));
    assign sout1 = a1 ^ b1 ^ c1 ^ f_inv ^ f_mask[{a1, b1, c1}];
    assign cout1 = f_stuck ? 1'b0 : ((a1 & b1) | (a1 & c1) | (b1 & c1));

    fa_vector_driver #(.HOLD_CYCLES(2), .NUM_PASSES(1)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .A(a0), .B(b0), .Cin(c0),
        .Sout(sout0), .Cout(cout0), .busy(busy0), .done(done0),
        .vec_idx(vec0), .mismatch(mis0), .err_cnt(err0)
    );

    fa_vector_driver #(.HOLD_CYCLES(1), .NUM_PASSES(3)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .A(a1), .B(b1), .Cin(c1),
        .Sout(sout1), .Cout(cout1), .busy(busy1), .done(done1),
        .vec_idx(vec1), .mismatch(mis1), .err_cnt(err1)
    );

    typedef struct {
        int busy;
        int done;
        int vec;
        int drv;
        int mis;
        int err;
    } exp_t;

    function automatic bit vecFails(input int v);
        int a, b, c, tot, good_s, good_c, bad_s, bad_c;
        a      = (v >> 2) & 1;
        b      = (v >> 1) & 1;
        c      = v & 1;
        tot    = a + b + c;
        good_s = tot % 2;
        good_c = tot / 2;
        bad_s  = good_s ^ int'(f_inv) ^ int'(f_mask[v]);
        bad_c  = f_stuck ? 0 : good_c;
        return (bad_s != good_s) || (bad_c != good_c);
    endfunction

    // k counts edges since the edge that sampled start; k < 1 means idle/reset values.
    function automatic exp_t model(input int k, input int h, input int p);
        exp_t e;
        int per, len, j, slots, cnt;
        per = h + 1;
        len = 8 * per * p;
        e = '{default: 0};
        if (k < 1) return e;
        if (k <= len) begin
            j      = k - 1;
            e.busy = 1;
            e.vec  = (j / per) % 8;
            e.drv  = e.vec;
            slots  = j / per;
            if (j > 0 && j % per == 0 && vecFails((slots - 1) % 8)) e.mis = 1;
        end else begin
            e.done = 1;
            e.vec  = 7;
            slots  = 8 * p;
            if (k == len + 1 && vecFails(7)) e.mis = 1;
        end
        cnt = 0;
        for (int s = 0; s < slots; s++) begin
            if (vecFails(s % 8)) cnt++;
        end
        e.err = (cnt > 15) ? 15 : cnt;
        return e;
    endfunction

    task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp_v);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic s, input logic r);
        if (inst == 0) begin
            start0 = s;
            rst0   = r;
        end else begin
            start1 = s;
            rst1   = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int inst, input int k);
        exp_t e;
        if (inst == 0) begin
            e = model(k, 2, 1);
            cmp(tag, "busy", 32'(busy0), 32'(e.busy));
            cmp(tag, "done", 32'(done0), 32'(e.done));
            cmp(tag, "vec_idx", 32'(vec0), 32'(e.vec));
            cmp(tag, "abc", 32'({a0, b0, c0}), 32'(e.drv));
            cmp(tag, "pulse", 32'(mis0), 32'(e.mis));
            cmp(tag, "err_cnt", 32'(err0), 32'(e.err));
        end else begin
            e = model(k, 1, 3);
            cmp(tag, "busy", 32'(busy1), 32'(e.busy));
            cmp(tag, "done", 32'(done1), 32'(e.done));
            cmp(tag, "vec_idx", 32'(vec1), 32'(e.vec));
            cmp(tag, "abc", 32'({a1, b1, c1}), 32'(e.drv));
            cmp(tag, "pulse", 32'(mis1), 32'(e.mis));
            cmp(tag, "err_cnt", 32'(err1), 32'(e.err));
        end
    endtask

    // Launches a run and checks every cycle up to k=upto; start is re-asserted for k in [s_lo,s_hi].
    task automatic runCheck(input string tag, input int inst, input int upto,
                            input int s_lo, input int s_hi);
        applyStimulus(inst, 1'b1, 1'b0);
        for (int k = 1; k <= upto; k++) begin
            applyStimulus(inst, (k >= s_lo && k <= s_hi), 1'b0);
            checkOutput(tag, inst, k);
        end
    endtask

    initial begin
        f_inv   = 1'b0;
        f_stuck = 1'b0;
        f_mask  = 8'h00;
        start1  = 1'b0;
        rst1    = 1'b1;
        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b1);
        rst1 = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("reset0", 0, -1);
        checkOutput("reset1", 1, -1);

        $display("[TB] correct adder, H=2 P=1");
        runCheck("run_ok", 0, 27, 0, -1);

        $display("[TB] Cout stuck at 0, restart from DONE");
        f_stuck = 1'b1;
        runCheck("cout_stuck", 0, 27, 0, -1);

        $display("[TB] random Sout faults, start re-asserted during vector 4");
        f_stuck = 1'b0;
        f_mask  = 8'($urandom);
        runCheck("busy_start", 0, 27, 13, 16);

        $display("[TB] inverted Sout, H=1 P=3, saturation");
        f_mask = 8'h00;
        f_inv  = 1'b1;
        runCheck("sat", 1, 51, 0, -1);

        f_inv = 1'b0;
        for (int r = 0; r < 2; r++) begin
            f_mask  = 8'($urandom);
            f_stuck = 1'($urandom_range(0, 1));
            $display("[TB] random run %0d mask=%02h stuck=%0d", r, f_mask, f_stuck);
            runCheck("rand_run", 1, 50, 0, -1);
        end

        $display("[TB] reset during CHECK of vector 5");
        f_mask  = 8'h00;
        f_stuck = 1'b1;
        runCheck("pre_rst", 0, 18, 0, -1);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("rst_mid", 0, -1);
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("rst_over_start", 0, -1);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("rst_stay_idle", 0, -1);
        f_stuck = 1'b0;
        runCheck("fresh_run", 0, 26, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
